// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the clock divider bank.
// Holds the per-channel config record and the clog2 helper.
package clk_div_pkg;

  localparam int DEF_DIV = 2;
  localparam int DEF_LOCK_CYCLES = 64;
  localparam int DIV_W_MAX = 32;

  typedef struct packed {
    logic [DIV_W_MAX-1:0] div;
    logic [DIV_W_MAX-1:0] phase;
  } ch_cfg_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Config, enable and output bundle of the divider bank.
// The master drives configuration; the slave is the bank.
interface clk_div_bank_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W = 16
);

  localparam int CH_W =
    (clk_div_pkg::clog2(NUM_CH) < 1) ? 1 :
    clk_div_pkg::clog2(NUM_CH);

  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic [DIV_W-1:0]  cfg_phase;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] outclk;
  logic [NUM_CH-1:0] tick;
  logic              locked;

  modport master (
    output cfg_we, cfg_ch, cfg_div,
    output cfg_phase, ch_en,
    input  outclk, tick, locked
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_div,
    input  cfg_phase, ch_en,
    output outclk, tick, locked
  );

endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: shadowed ratio/phase, glitch-free
// ratio switch at the period wrap, registered outclk/tick.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    en,
  input  logic    we,
  input  ch_cfg_t cfg,
  output logic    outclk,
  output logic    tick,
  output logic    pend
);

  logic [DIV_W-1:0] d, s, p, cnt;
  logic [DIV_W-1:0] d_n, cnt_n;
  logic [DIV_W-1:0] wdiv, wphase;
  logic             pend_n, en_q;

  assign wdiv = cfg.div[DIV_W-1:0];
  assign wphase = cfg.phase[DIV_W-1:0];

  if (DIV_W < DIV_W_MAX) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^{cfg.div[DIV_W_MAX-1:DIV_W],
                         cfg.phase[DIV_W_MAX-1:DIV_W]};
  end

  always_comb begin
    d_n = d;
    cnt_n = cnt;
    pend_n = pend;
    if (!en) begin
      if (pend) begin
        d_n = s;
        pend_n = 1'b0;
      end
    end else if (!en_q) begin
      cnt_n = (p < d) ? p : '0;
    end else if (cnt >= d - DIV_W'(1)) begin
      // ratio only changes here, so a period is never cut short
      cnt_n = '0;
      if (pend) begin
        d_n = s;
        pend_n = 1'b0;
      end
    end else begin
      cnt_n = cnt + DIV_W'(1);
    end
    if (we) pend_n = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d <= DIV_W'(DEFAULT_DIV);
      s <= DIV_W'(DEFAULT_DIV);
      p <= '0;
      cnt <= '0;
      pend <= 1'b0;
      en_q <= 1'b0;
      outclk <= 1'b0;
      tick <= 1'b0;
    end else begin
      d <= d_n;
      cnt <= cnt_n;
      pend <= pend_n;
      en_q <= en;
      if (we) begin
        s <= wdiv;
        p <= wphase;
      end
      outclk <= en && ((d_n == DIV_W'(1)) ||
                       (cnt_n < (d_n >> 1)));
      tick <= en && (cnt_n == '0);
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH clock dividers with write decode and
// a shared settle counter driving locked.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W = 16,
  parameter int DEFAULT_DIV = DEF_DIV,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input logic           refclk,
  input logic           rst,
  clk_div_bank_if.slave bus
);

  localparam int CH_W =
    (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH);
  localparam int LOCK_W =
    (clog2(LOCK_CYCLES + 1) < 1) ? 1 :
    clog2(LOCK_CYCLES + 1);

  logic              wr_ok;
  ch_cfg_t           wr_cfg;
  logic [NUM_CH-1:0] pend, oclk, otick;
  logic [LOCK_W-1:0] lock_cnt;

  assign wr_ok = bus.cfg_we &&
    ({1'b0, bus.cfg_ch} < (CH_W + 1)'(NUM_CH));

  assign wr_cfg.div = DIV_W_MAX'(
    (bus.cfg_div == '0) ? DIV_W'(1) : bus.cfg_div);
  assign wr_cfg.phase = DIV_W_MAX'(bus.cfg_phase);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_ch #(
      .DIV_W(DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk(refclk),
      .rst(rst),
      .en(bus.ch_en[i]),
      .we(wr_ok && (bus.cfg_ch == CH_W'(i))),
      .cfg(wr_cfg),
      .outclk(oclk[i]),
      .tick(otick[i]),
      .pend(pend[i])
    );
  end

  assign bus.outclk = oclk;
  assign bus.tick = otick;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst)
      lock_cnt <= '0;
    else if (wr_ok || (|pend))
      lock_cnt <= '0;
    else if (lock_cnt != LOCK_W'(LOCK_CYCLES))
      lock_cnt <= lock_cnt + LOCK_W'(1);
  end

  assign bus.locked = (lock_cnt == LOCK_W'(LOCK_CYCLES));

endmodule
